aes_round_sched: RTL and testbench

//  Sequences one AES-128 block encryption through a shared single-round

---
 rtl/aes_round_sched.sv | 113 +++++++++++
 tb/tb_aes_round_sched.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_sched.sv
// Sequencer for one AES-128 block through a shared single-round datapath.
// Holds the state register, round counter and round-key index; one block in flight.
module aes_round_sched #(
   parameter int NR = 10,
   parameter int KW = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [127:0]    in_data,
   output logic [KW-1:0]   key_addr,
   input  logic [127:0]    key_in,
   output logic [127:0]    dp_state,
   output logic [127:0]    dp_key,
   output logic            dp_skip_mix,
   input  logic [127:0]    dp_result,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [127:0]    out_data,
   output logic            busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ROUND = 2'd1,
      S_FINAL = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [KW-1:0] LP_LAST_ROUND = KW'(NR - 1);
   localparam logic [KW-1:0] LP_FINAL_KEY  = KW'(NR);
   localparam logic [KW-1:0] LP_ONE        = KW'(1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [127:0]     r_state_reg;
   logic [KW-1:0]    r_round_cnt;
   logic             w_accept;

   assign w_accept = in_valid & in_ready;
   assign dp_state = r_state_reg;
   assign dp_key   = key_in;
   assign out_data = r_state_reg;

   // FSM state register plus the two FSM-decoded registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         out_valid <= (w_state_nxt == S_DONE);
         busy      <= (w_state_nxt != S_IDLE);
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  w_state_nxt = w_accept ? S_ROUND : S_IDLE;
         S_ROUND: w_state_nxt = (r_round_cnt == LP_LAST_ROUND) ? S_FINAL : S_ROUND;
         S_FINAL: w_state_nxt = S_DONE;
         S_DONE: begin
            if (out_ready) begin
               w_state_nxt = in_valid ? S_ROUND : S_IDLE;
            end else begin
               w_state_nxt = S_DONE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Combinational outputs; DONE presents key 0 so a back-to-back accept loads correctly
   always_comb begin
      in_ready    = 1'b0;
      key_addr    = '0;
      dp_skip_mix = 1'b0;
      case (r_state)
         S_IDLE:  in_ready = 1'b1;
         S_ROUND: key_addr = r_round_cnt;
         S_FINAL: begin
            key_addr    = LP_FINAL_KEY;
            dp_skip_mix = 1'b1;
         end
         S_DONE:  in_ready = out_ready;
         default: in_ready = 1'b0;
      endcase
   end

   // State register and round counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state_reg <= 128'h0;
         r_round_cnt <= '0;
      end else if (w_accept) begin
         r_state_reg <= in_data ^ key_in;
         r_round_cnt <= LP_ONE;
      end else if (r_state == S_ROUND) begin
         r_state_reg <= dp_result;
         r_round_cnt <= r_round_cnt + LP_ONE;
      end else if (r_state == S_FINAL) begin
         r_state_reg <= dp_result;
      end else begin
         r_state_reg <= r_state_reg;
         r_round_cnt <= r_round_cnt;
      end
   end

endmodule

// File: tb/tb_aes_round_sched.sv
// Randomized self-checking bench for aes_round_sched with an XOR or full AES
// round datapath and a behavioural key store/encryption model.
module tb_aes_round_sched;

   localparam int NR = 10;
   localparam int KW = 4;

   logic            clk;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [127:0]    in_data;
   logic [KW-1:0]   key_addr;
   logic [127:0]    key_in;
   logic [127:0]    dp_state;
   logic [127:0]    dp_key;
   logic            dp_skip_mix;
   logic [127:0]    dp_result;
   logic            out_valid;
   logic            out_ready;
   logic [127:0]    out_data;
   logic            busy;

   int              n_cmp;
   int              n_err;
   bit              aes_mode;
   logic [127:0]    keys [0:15];
   logic [KW-1:0]   seq_addr [0:47];
   logic            seq_skip [0:47];

   aes_round_sched #(.NR(NR), .KW(KW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .key_addr(key_addr), .key_in(key_in),
      .dp_state(dp_state), .dp_key(dp_key), .dp_skip_mix(dp_skip_mix),
      .dp_result(dp_result),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- AES reference arithmetic ----------------
   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] r;
      logic [7:0] s;
      r = 8'h01;
      s = a;
      for (int i = 0; i < 7; i++) begin
         s = gmul(s, s);
         r = gmul(r, s);
      end
      if (a == 8'h00) r = 8'h00;
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                              input logic last);
      logic [7:0]   b [16];
      logic [7:0]   t [16];
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] o;
      for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            t[4*c+r] = b[4*((c+r)%4)+r];
      if (!last) begin
         for (int c = 0; c < 4; c++) begin
            a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
            t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
         end
      end
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
      return o ^ k;
   endfunction

   task automatic expand_key(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] tmp;
      logic [7:0]  rcon;
      rcon = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sbox(tmp[31:24]), sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0])};
            tmp = tmp ^ {rcon, 24'h000000};
            rcon = xt(rcon);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int r = 0; r <= NR; r++) keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      for (int r = NR + 1; r < 16; r++) keys[r] = 128'h0;
   endtask

   // Whole-block reference: pt -> ciphertext from the current key set
   function automatic logic [127:0] ref_block(input logic [127:0] pt);
      logic [127:0] s;
      s = pt ^ keys[0];
      for (int r = 1; r <= NR; r++)
         s = aes_mode ? aes_round(s, keys[r], r == NR) : (s ^ keys[r]);
      return s;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Key store and round datapath environment
   always_comb begin
      key_in    = keys[key_addr];
      dp_result = aes_mode ? aes_round(dp_state, dp_key, dp_skip_mix) : (dp_state ^ dp_key);
   end

   // ---------------- stimulus helpers (no checks inside) ----------------
   task automatic wait_done(output int lat, output logic [127:0] data);
      lat = 0;
      while (!out_valid && lat < 40) begin
         seq_addr[lat+1] = key_addr;
         seq_skip[lat+1] = dp_skip_mix;
         @(posedge clk); #1;
         lat++;
      end
      data = out_data;
   endtask

   task automatic do_block(input logic [127:0] pt, output int lat, output logic [127:0] data);
      in_valid = 1'b1;
      in_data  = pt;
      seq_addr[0] = key_addr;
      seq_skip[0] = dp_skip_mix;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = rnd128();
      wait_done(lat, data);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
      n_cmp++; if (dp_skip_mix !== 1'b0) begin n_err++; $display("FAIL reset_skip got %b want 0", dp_skip_mix); end
      n_cmp++; if (out_data !== 128'h0) begin n_err++; $display("FAIL reset_out_data got %h want 0", out_data); end
      n_cmp++; if (key_addr !== 4'd0) begin n_err++; $display("FAIL reset_key_addr got %0d want 0", key_addr); end
   endtask

   task automatic test_zero_block();
      int lat;
      logic [127:0] d;
      aes_mode = 1'b0;
      for (int i = 0; i < 16; i++) keys[i] = 128'(i);
      out_ready = 1'b1;
      do_block(128'h0, lat, d);
      n_cmp++; if (lat !== NR) begin n_err++; $display("FAIL zero_latency got %0d want %0d", lat, NR); end
      n_cmp++; if (d !== 128'h0B) begin n_err++; $display("FAIL zero_data got %h want 0b", d); end
      for (int i = 0; i <= NR; i++) begin
         n_cmp++; if (seq_addr[i] !== KW'(i)) begin n_err++; $display("FAIL key_addr_seq[%0d] got %0d want %0d", i, seq_addr[i], i); end
         n_cmp++; if (seq_skip[i] !== (i == NR)) begin n_err++; $display("FAIL skip_seq[%0d] got %b want %b", i, seq_skip[i], i == NR); end
      end
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL zero_drain_valid got %b want 0", out_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL zero_drain_busy got %b want 0", busy); end
   endtask

   task automatic test_random_xor();
      int lat;
      logic [127:0] d, pt, exp_d;
      aes_mode = 1'b0;
      out_ready = 1'b1;
      for (int n = 0; n < 6; n++) begin
         for (int i = 0; i < 16; i++) keys[i] = rnd128();
         pt = rnd128();
         exp_d = ref_block(pt);
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         do_block(pt, lat, d);
         n_cmp++; if (lat !== NR) begin n_err++; $display("FAIL xor_latency[%0d] got %0d want %0d", n, lat, NR); end
         n_cmp++; if (d !== exp_d) begin n_err++; $display("FAIL xor_data[%0d] got %h want %h", n, d, exp_d); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_fips();
      int lat;
      logic [127:0] d;
      aes_mode = 1'b1;
      out_ready = 1'b1;
      expand_key(128'h000102030405060708090a0b0c0d0e0f);
      do_block(128'h00112233445566778899aabbccddeeff, lat, d);
      n_cmp++; if (lat !== NR) begin n_err++; $display("FAIL fips_latency got %0d want %0d", lat, NR); end
      n_cmp++; if (d !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin n_err++; $display("FAIL fips_data got %h want 69c4e0d86a7b0430d8cdb78070b4c55a", d); end
      @(posedge clk); #1;
   endtask

   task automatic test_random_aes();
      int lat;
      logic [127:0] d, pt, exp_d;
      aes_mode = 1'b1;
      out_ready = 1'b1;
      for (int n = 0; n < 3; n++) begin
         expand_key(rnd128());
         pt = rnd128();
         exp_d = ref_block(pt);
         do_block(pt, lat, d);
         n_cmp++; if (d !== exp_d) begin n_err++; $display("FAIL aes_data[%0d] got %h want %h", n, d, exp_d); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_backpressure();
      int lat;
      logic [127:0] d, pt, exp_d;
      aes_mode = 1'b0;
      for (int i = 0; i < 16; i++) keys[i] = rnd128();
      pt = rnd128();
      exp_d = ref_block(pt);
      out_ready = 1'b0;
      do_block(pt, lat, d);
      n_cmp++; if (d !== exp_d) begin n_err++; $display("FAIL bp_data got %h want %h", d, exp_d); end
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d] got %b want 1", c, out_valid); end
         n_cmp++; if (out_data !== exp_d) begin n_err++; $display("FAIL bp_stable[%0d] got %h want %h", c, out_data, exp_d); end
         n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d] got %b want 0", c, in_ready); end
         n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL bp_busy[%0d] got %b want 1", c, busy); end
      end
      out_ready = 1'b1;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_after_valid got %b want 0", out_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_after_busy got %b want 0", busy); end
   endtask

   task automatic test_back_to_back();
      int lat;
      logic [127:0] d, pa, pb, ea, eb;
      aes_mode = 1'b0;
      for (int i = 0; i < 16; i++) keys[i] = rnd128();
      pa = rnd128();
      pb = rnd128();
      ea = ref_block(pa);
      eb = ref_block(pb);
      out_ready = 1'b0;
      do_block(pa, lat, d);
      n_cmp++; if (d !== ea) begin n_err++; $display("FAIL b2b_first got %h want %h", d, ea); end
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = pb;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready got %b want 1", in_ready); end
      n_cmp++; if (key_addr !== 4'd0) begin n_err++; $display("FAIL b2b_key_addr got %0d want 0", key_addr); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = rnd128();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_valid_drop got %b want 0", out_valid); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy got %b want 1", busy); end
      wait_done(lat, d);
      n_cmp++; if (lat !== NR) begin n_err++; $display("FAIL b2b_latency got %0d want %0d", lat, NR); end
      n_cmp++; if (d !== eb) begin n_err++; $display("FAIL b2b_second got %h want %h", d, eb); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      int lat;
      logic [127:0] d, pt, exp_d;
      aes_mode = 1'b1;
      out_ready = 1'b1;
      expand_key(rnd128());
      in_valid = 1'b1;
      in_data  = rnd128();
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      n_cmp++; if (key_addr !== 4'd4) begin n_err++; $display("FAIL mid_round_cnt got %0d want 4", key_addr); end
      rst = 1'b1;
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid got %b want 0", out_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy got %b want 0", busy); end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_after_in_ready got %b want 1", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_after_valid got %b want 0", out_valid); end
      pt = rnd128();
      exp_d = ref_block(pt);
      do_block(pt, lat, d);
      n_cmp++; if (lat !== NR) begin n_err++; $display("FAIL mid_new_latency got %0d want %0d", lat, NR); end
      n_cmp++; if (d !== exp_d) begin n_err++; $display("FAIL mid_new_data got %h want %h", d, exp_d); end
      @(posedge clk); #1;
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      aes_mode  = 1'b0;
      for (int i = 0; i < 16; i++) keys[i] = 128'h0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 128'h0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      test_reset();
      test_zero_block();
      test_random_xor();
      test_fips();
      test_random_aes();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
